// File: rtl/router_buffered_if.sv
// rtl/router_buffered_if.sv - producer/consumer handshake bundle for router_buffered
interface router_buffered_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_PORTS)
);
    logic [DATA_WIDTH-1:0]           din;
    logic                            din_valid;
    logic                            din_ready;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout;
    logic [NUM_PORTS-1:0]            dout_valid;
    logic [NUM_PORTS-1:0]            dout_ready;
    logic                            addr_err;

    // Producer and consumers, driving the router
    modport master (
        output din, din_valid, addr, dout_ready,
        input  din_ready, dout, dout_valid, addr_err
    );

    // The router itself
    modport slave (
        input  din, din_valid, addr, dout_ready,
        output din_ready, dout, dout_valid, addr_err
    );
endinterface

// File: rtl/router_buffered.sv
// rtl/router_buffered.sv - 1-to-N stream router with per-channel FIFOs (option: ROUTER_ZERO_IDLE_EN)
module router_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic            clk,
    input  logic            reset,
    router_buffered_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem    [NUM_PORTS][FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr [NUM_PORTS];
    logic [PW-1:0]         wr_ptr [NUM_PORTS];
    logic [CW-1:0]         count  [NUM_PORTS];

    logic [ADDR_WIDTH-1:0]           addr_q;
    logic                            addr_legal;
    logic                            sel_full;
    logic                            accept;
    logic [NUM_PORTS-1:0]            full;
    logic [NUM_PORTS-1:0]            valid;
    logic [NUM_PORTS-1:0]            push_en;
    logic [NUM_PORTS-1:0]            pop_en;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dout_flat;
    logic                            addr_err_q;

    assign addr_q     = bus.addr;
    assign addr_legal = {1'b0, addr_q} < (ADDR_WIDTH + 1)'(NUM_PORTS);

    // Per-channel status and the addr-selected backpressure; illegal addresses are always taken
    always_comb begin
        sel_full = 1'b0;
        full     = '0;
        valid    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            full[i]  = (count[i] == CW'(FIFO_DEPTH));
            valid[i] = (count[i] != '0);
            if (addr_legal && addr_q == ADDR_WIDTH'(i)) begin
                sel_full = full[i];
            end
        end
    end

    assign bus.din_ready = !sel_full;
    assign accept        = bus.din_valid && !sel_full;

    // Push/pop strobes; a full channel never accepts even while it pops this cycle
    always_comb begin
        push_en = '0;
        pop_en  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_en[i] = !reset && accept && addr_legal && (addr_q == ADDR_WIDTH'(i));
            pop_en[i]  = valid[i] && bus.dout_ready[i];
        end
    end

    // Pointer and occupancy bookkeeping per channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push_en[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
                end
                if (pop_en[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
                end
                if (push_en[i] && !pop_en[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!push_en[i] && pop_en[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // Payload storage; no reset, contents are simply abandoned on reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_en[i]) begin
                mem[i][wr_ptr[i]] <= bus.din;
            end
        end
    end

    // One-cycle error pulse for beats swallowed at an out-of-range address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= bus.din_valid && !addr_legal;
        end
    end

    // Head-of-queue output mux, optionally zeroed while the channel is empty
    always_comb begin
        dout_flat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef ROUTER_ZERO_IDLE_EN
            dout_flat[i*DATA_WIDTH +: DATA_WIDTH] = valid[i] ? mem[i][rd_ptr[i]] : '0;
`else
            dout_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
`endif
        end
    end

    assign bus.dout       = dout_flat;
    assign bus.dout_valid = valid;
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_router_buffered.sv
// tb/tb_router_buffered.sv - self-checking bench for router_buffered
module tb_router_buffered;
    localparam int DW    = 32;
    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    router_buffered_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();
    router_buffered_if #(.DATA_WIDTH(DW), .NUM_PORTS(3))  bus3 ();

    router_buffered #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    router_buffered #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NP][$];
    logic [DW-1:0] out0 [$];
    bit            last_rdy;
    bit            last_acc;

    typedef struct {
        bit            v;
        int            a;
        logic [DW-1:0] d;
        logic [NP-1:0] r;
        bit            e_rdy;
        logic [NP-1:0] e_val;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NP-1:0] ev;
        for (int i = 0; i < NP; i++) ev[i] = (mq[i].size() > 0);
        chk("dout_valid", 64'(bus.dout_valid), 64'(ev));
        chk("addr_err_idle", 64'(bus.addr_err), 64'd0);
        for (int i = 0; i < NP; i++) begin
            if (ev[i]) begin
                chk($sformatf("dout_ch%0d", i), 64'(bus.dout[i*DW +: DW]), 64'(mq[i][0]));
            end
`ifdef ROUTER_ZERO_IDLE_EN
            else begin
                chk($sformatf("dout_idle_ch%0d", i), 64'(bus.dout[i*DW +: DW]), 64'd0);
            end
`endif
        end
    endtask

    // Entered and left at posedge+1: drive, check ready, advance the model, clock, check outputs
    task automatic do_cycle(input bit v, input int a, input logic [DW-1:0] d, input logic [NP-1:0] r);
        bit exp_rdy;
        bus.din_valid  = v;
        bus.addr       = a[1:0];
        bus.din        = d;
        bus.dout_ready = r;
        #1;
        exp_rdy = (a >= NP) || (mq[a].size() < DEPTH);
        chk("din_ready", 64'(bus.din_ready), 64'(exp_rdy));
        last_rdy = bus.din_ready;
        last_acc = v && exp_rdy;
        if (bus.dout_valid[0] && r[0]) out0.push_back(bus.dout[DW-1:0]);
        for (int i = 0; i < NP; i++) begin
            if (r[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        end
        if (last_acc && a < NP) mq[a].push_back(d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic add_vec(input bit v, input int a, input logic [DW-1:0] d, input logic [NP-1:0] r,
                           input bit e_rdy, input logic [NP-1:0] e_val, input logic [DW-1:0] e_data);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.r = r; t.e_rdy = e_rdy; t.e_val = e_val; t.e_data = e_data;
        tbl.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        bit tog;
        int lo;

        bus.din_valid = 0; bus.addr = 0; bus.din = 0; bus.dout_ready = 0;
        bus3.din_valid = 0; bus3.addr = 0; bus3.din = 0; bus3.dout_ready = 0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_addr_err", 64'(bus.addr_err), 64'd0);
        chk("rst_din_ready", 64'(bus.din_ready), 64'd1);
`ifdef ROUTER_ZERO_IDLE_EN
        chk("rst_dout_zero", 64'(bus.dout == '0), 64'd1);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Route basic, then fill/backpressure on channel 2 and release
        add_vec(1, 0, 32'hA0, 4'hF, 1, 4'b0001, 32'hA0);
        add_vec(1, 1, 32'hA1, 4'hF, 1, 4'b0010, 32'hA1);
        add_vec(1, 2, 32'hA2, 4'hF, 1, 4'b0100, 32'hA2);
        add_vec(1, 3, 32'hA3, 4'hF, 1, 4'b1000, 32'hA3);
        add_vec(0, 0, 32'h0,  4'hF, 1, 4'b0000, 32'h0);
        add_vec(1, 2, 32'd1, 4'b1011, 1, 4'b0100, 32'd1);
        add_vec(1, 2, 32'd2, 4'b1011, 1, 4'b0100, 32'd1);
        add_vec(1, 2, 32'd3, 4'b1011, 1, 4'b0100, 32'd1);
        add_vec(1, 2, 32'd4, 4'b1011, 1, 4'b0100, 32'd1);
        add_vec(1, 2, 32'd5, 4'b1011, 0, 4'b0100, 32'd1);
        add_vec(0, 1, 32'd0, 4'b1011, 1, 4'b0100, 32'd1);
        add_vec(1, 2, 32'd5, 4'hF, 0, 4'b0100, 32'd2);
        add_vec(1, 2, 32'd5, 4'hF, 1, 4'b0100, 32'd3);
        add_vec(0, 0, 32'd0, 4'hF, 1, 4'b0100, 32'd4);
        add_vec(0, 0, 32'd0, 4'hF, 1, 4'b0100, 32'd5);
        add_vec(0, 0, 32'd0, 4'hF, 1, 4'b0000, 32'd0);

        foreach (tbl[k]) begin
            do_cycle(tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].r);
            chk($sformatf("tbl%0d_rdy", k), 64'(last_rdy), 64'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_valid", k), 64'(bus.dout_valid), 64'(tbl[k].e_val));
            lo = -1;
            for (int i = NP - 1; i >= 0; i--) if (tbl[k].e_val[i]) lo = i;
            if (lo >= 0) chk($sformatf("tbl%0d_data", k), 64'(bus.dout[lo*DW +: DW]), 64'(tbl[k].e_data));
        end

        // Wrap-around: 20 beats to channel 0 with a toggling consumer
        out0.delete();
        sent = 0;
        tog = 0;
        for (int c = 0; c < 300 && (sent < 20 || mq[0].size() > 0); c++) begin
            do_cycle(sent < 20, 0, 32'h100 + sent, {3'b111, tog});
            if (last_acc) sent++;
            tog = !tog;
        end
        chk("wrap_sent", 64'(sent), 64'd20);
        chk("wrap_out_count", 64'(out0.size()), 64'd20);
        for (int k = 0; k < 20 && k < out0.size(); k++) begin
            chk($sformatf("wrap_order%0d", k), 64'(out0[k]), 64'(32'h100 + k));
        end

        // Full channel 3 with a same-cycle pop: no slot reuse
        for (int k = 0; k < DEPTH; k++) do_cycle(1, 3, 32'h300 + k, 4'b0000);
        do_cycle(1, 3, 32'h3FF, 4'b1000);
        chk("full_pop_rdy", 64'(last_rdy), 64'd0);
        do_cycle(1, 3, 32'h3FE, 4'b0000);
        chk("full_pop_next_rdy", 64'(last_rdy), 64'd1);
        for (int k = 0; k < 6; k++) do_cycle(0, 0, 0, 4'hF);

        // Illegal address on the three-channel instance
        bus3.din_valid = 1; bus3.addr = 2'd3; bus3.din = 32'hBAD;
        #1;
        chk("illegal_rdy", 64'(bus3.din_ready), 64'd1);
        @(posedge clk); #1;
        bus3.din_valid = 0;
        chk("illegal_err_pulse", 64'(bus3.addr_err), 64'd1);
        chk("illegal_no_valid", 64'(bus3.dout_valid), 64'd0);
        @(posedge clk); #1;
        chk("illegal_err_clear", 64'(bus3.addr_err), 64'd0);

        // Randomized traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            do_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)), DW'($urandom), NP'($urandom));
        end
        for (int k = 0; k < 6; k++) do_cycle(0, 0, 0, 4'hF);

        // Reset asserted mid-operation with two entries in channels 0 and 1
        do_cycle(1, 0, 32'h500, 4'b0000);
        do_cycle(1, 0, 32'h501, 4'b0000);
        do_cycle(1, 1, 32'h510, 4'b0000);
        do_cycle(1, 1, 32'h511, 4'b0000);
        chk("pre_rst_valid", 64'(bus.dout_valid), 64'b0011);
        bus.din_valid = 1; bus.addr = 0; bus.din = 32'hDEAD; bus.dout_ready = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_held_rdy", 64'(bus.din_ready), 64'd1);
        @(posedge clk); #1;
        chk("rst_no_write", 64'(bus.dout_valid), 64'd0);
        bus.din_valid = 0;
        reset = 1'b0;
        for (int i = 0; i < NP; i++) mq[i].delete();
        do_cycle(1, 0, 32'h600, 4'b0000);
        do_cycle(1, 0, 32'h601, 4'b0000);
        chk("rst_first_out", 64'(bus.dout[DW-1:0]), 64'h600);
        do_cycle(0, 0, 0, 4'b0001);
        chk("rst_second_out", 64'(bus.dout[DW-1:0]), 64'h601);
        do_cycle(0, 0, 0, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_buffered.md
# router_buffered

Parametrised, buffered successor to the combinational 1-to-4 data router. It routes a single valid/ready input stream to one of `NUM_PORTS` output channels selected by `addr`, with a per-channel FIFO so that a stalled consumer back-pressures only traffic addressed to it. It sits between a single producer and several independent consumers. Idle outputs optionally read as zero.

## Interface
- `DATA_WIDTH`, 32, payload width in bits.
- `NUM_PORTS`, 4, number of output channels; legal range 2..16.
- `FIFO_DEPTH`, 4, entries per channel FIFO; legal range 2..16, need not be a power of two.
- `ADDR_WIDTH`, `$clog2(NUM_PORTS)`, derived; do not override.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  DATA_WIDTH  input payload.
- `din_valid`  in  1  input beat present.
- `din_ready`  out  1  input beat accepted when `din_valid & din_ready`.
- `addr`  in  ADDR_WIDTH  destination channel; qualified by `din_valid`.
- `dout`  out  NUM_PORTS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `dout_valid`  out  NUM_PORTS  bit i: channel i head entry valid.
- `dout_ready`  in  NUM_PORTS  bit i: consumer i takes its head entry this cycle.
- `addr_err`  out  1  registered one-cycle pulse when a beat with `addr >= NUM_PORTS` is accepted.

## Operation
- Each channel has its own FIFO: storage array, read pointer, write pointer, and an occupancy count of width `$clog2(FIFO_DEPTH+1)`.
- Pointers increment modulo `FIFO_DEPTH` and wrap to 0 after `FIFO_DEPTH-1`.
- `din_ready` is combinational from `addr`:
  - 1 when `addr >= NUM_PORTS`. The beat is accepted and discarded, and `addr_err` pulses on the next cycle.
  - Otherwise `din_ready = !full[addr]`.
  - `din_ready` does not depend on `din_valid`.
- Push: on `din_valid & din_ready` with a legal `addr`, `din` is written at the write pointer of channel `addr`; the write pointer and count increment.
- Pop: on `dout_valid[i] & dout_ready[i]`, channel i's read pointer increments and its count decrements. `dout_ready[i]` while `dout_valid[i]=0` has no effect.
- `dout_valid[i] = (count[i] != 0)`.
- Simultaneous push and pop on the same channel:
  - The count is unchanged and both pointers advance.
  - A full channel still reports `din_ready=0` even while popping in the same cycle; there is no same-cycle slot reuse.
- Pops on different channels are independent and may all occur in one cycle.
- Ordering is preserved within a channel. There is no ordering guarantee across channels.
- Reset, including when asserted mid-transfer:
  - All pointers, counts, `dout_valid` and `addr_err` clear immediately.
  - All buffered data is lost.
  - `din_ready` follows `addr` (1 for every legal address) while `reset` is high, but nothing is written.

## Timing
- Latency: a beat accepted at edge N appears on `dout_valid`/`dout` after edge N. There is no combinational input-to-output bypass.
- Throughput: one input beat per cycle; each channel drains one beat per cycle.
- The only combinational paths are `addr` → `din_ready` and read pointer → `dout` mux.
- Reset values:
  - `dout_valid` = 0.
  - `addr_err` = 0.
  - `dout` = 0 with `ROUTER_ZERO_IDLE_EN`; undefined-but-stable otherwise.

## Configuration
- `ROUTER_ZERO_IDLE_EN` defined: `dout[i]` is forced to all-zero whenever `dout_valid[i]=0`, preserving the legacy "undriven channel reads zero" behaviour.
- `ROUTER_ZERO_IDLE_EN` undefined: `dout[i]` presents the storage entry at the read pointer unconditionally. Its value is meaningless when `dout_valid[i]=0`; this saves the output AND gates.

## Test plan
- Route basic: after reset, send 0xA0..0xA3 with addr 0..3, all `dout_ready=1`.
  - Required: each channel shows its value for exactly one cycle, one cycle after acceptance.
  - Required (with `ROUTER_ZERO_IDLE_EN`): other channels read 0.
- Fill/backpressure: hold `dout_ready[2]=0` and send 5 beats to addr 2 (`FIFO_DEPTH=4`).
  - Required: 4 beats accepted, then `din_ready=0` for addr 2.
  - Required: `din_ready=1` for addr 1 in the same cycle.
  - On release, output order is 1,2,3,4,5.
- Wrap-around: stream 20 sequential beats to addr 0 with `dout_ready[0]` toggling every cycle.
  - Required: all 20 emerge in order with no loss or duplication.
  - Required: the count never exceeds 4.
- Full + simultaneous pop: channel 3 full, `dout_ready[3]=1`, `din_valid=1` to addr 3.
  - Required: `din_ready=0` that cycle, count drops to 3.
  - Required: `din_ready=1` on the next cycle.
- Illegal address (`NUM_PORTS=3`): send addr 3 with `din_valid=1`.
  - Required: `din_ready=1`, `addr_err=1` for one cycle after, no `dout_valid` change.
- Reset mid-operation: assert `reset` asynchronously with channels 0 and 1 holding 2 entries each.
  - Required: `dout_valid=0` before the next clock edge.
  - Required: after deassert, the first beat sent to channel 0 is the first one out.
